// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared types and default sizing for the Quad-SPI row transmitter
package qspi_pkg;

    // Row transmitter sequencing: chip-select setup, data beats, chip-select hold.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } tx_state_e;

    localparam int QSPI_DWIDTH        = 16;
    localparam int QSPI_NLANES        = 4;
    localparam int QSPI_WORDS_PER_ROW = 9;   // 8 data words + 1 address word
    localparam int QSPI_CLK_DIV       = 2;   // clk cycles per sclk half-period

endpackage

// File: rtl/qspi_sclk_gen.sv
// rtl/qspi_sclk_gen.sv - mode-0 sclk generator with low/high phase tick outputs
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   en          run the generator; while low sclk idles low and the phase restarts
//   sclk        QSPI clock, first CLK_DIV cycles of every beat low, next CLK_DIV high
//   fall_tick   first cycle of a low phase
//   rise_tick   first cycle of a high phase
//   beat_end    last cycle of a high phase (beat complete)
module qspi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic fall_tick,
    output logic rise_tick,
    output logic beat_end
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] phase_cnt;
    logic          high;

    // Restarting from phase 0 / low whenever en drops means the first enabled
    // cycle is always the start of a low phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
            high      <= 1'b0;
        end else if (!en) begin
            phase_cnt <= '0;
            high      <= 1'b0;
        end else if (phase_cnt == PHASE_LAST) begin
            phase_cnt <= '0;
            high      <= ~high;
        end else begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    assign sclk      = high;
    assign fall_tick = en && !high && (phase_cnt == '0);
    assign rise_tick = en &&  high && (phase_cnt == '0);
    assign beat_end  = en &&  high && (phase_cnt == PHASE_LAST);

endmodule

// File: rtl/qspi_row_tx.sv
// rtl/qspi_row_tx.sv - fetches one row of words from the FIFO interface and sends it on Quad-SPI
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   start        single-cycle row request (ignored while busy or fifo_empty)
//   fifo_empty   FIFO has no row to send
//   rdata_spi    current FIFO word, combinationally valid
//   shift_en     one-cycle pulse: word captured, FIFO interface advances
//   sclk         QSPI clock, mode 0, idles low
//   cs_n         chip select, low during setup and data beats
//   io_out       QSPI data lanes, MSB nibble first
//   io_oe        data lane output enable
//   busy         row transfer in progress
//   done         one-cycle pulse on the last hold cycle
module qspi_row_tx
    import qspi_pkg::*;
#(
    parameter int DWIDTH        = QSPI_DWIDTH,
    parameter int NLANES        = QSPI_NLANES,
    parameter int WORDS_PER_ROW = QSPI_WORDS_PER_ROW,
    parameter int CLK_DIV       = QSPI_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] rdata_spi,
    output logic              shift_en,
    output logic              sclk,
    output logic              cs_n,
    output logic [NLANES-1:0] io_out,
    output logic              io_oe,
    output logic              busy,
    output logic              done
);

    localparam int BEATS = DWIDTH / NLANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WW    = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_ROW - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(CLK_DIV - 1);

    tx_state_e         state;
    tx_state_e         state_nxt;
    logic [CW-1:0]     wait_cnt;     // cycle count within SETUP or HOLD
    logic              wait_last;
    logic [BW-1:0]     beat_cnt;
    logic [WW-1:0]     word_cnt;
    logic              row_last;     // last beat of last word has been clocked out
    logic [DWIDTH-1:0] shreg;
    logic              fall_tick;
    logic              rise_tick;
    logic              beat_end;

    qspi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state == SHIFT),
        .sclk      (sclk),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick),
        .beat_end  (beat_end)
    );

    assign wait_last = (wait_cnt == WAIT_LAST);
    assign io_out    = shreg[DWIDTH-1 -: NLANES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        cs_n      = 1'b1;
        io_oe     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !fifo_empty) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                cs_n  = 1'b0;
                io_oe = 1'b1;
                busy  = 1'b1;
                if (wait_last) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                cs_n     = 1'b0;
                io_oe    = 1'b1;
                busy     = 1'b1;
                shift_en = fall_tick && (beat_cnt == '0);
                if (beat_end && row_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (wait_last) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shared dwell counter: restarts on every state change so SETUP and HOLD
    // each last exactly CLK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            wait_cnt <= '0;
        end else if (state == SETUP || state == HOLD) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Counters advance on the sclk rise, so at the next low-phase start
    // beat_cnt already names the beat about to be driven: 0 means fetch a new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            word_cnt <= '0;
            row_last <= 1'b0;
        end else if (state == SETUP) begin
            beat_cnt <= '0;
            word_cnt <= '0;
            row_last <= 1'b0;
        end else if (state == SHIFT && rise_tick) begin
            if (beat_cnt == BEAT_LAST) begin
                beat_cnt <= '0;
                if (word_cnt == WORD_LAST) begin
                    row_last <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Loads and shifts happen only at the start of a low phase, so the lanes
    // settle while sclk is low and stay put through the high phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (state == SETUP) begin
            shreg <= '0;
        end else if (state == SHIFT) begin
            if (beat_end && row_last) begin
                shreg <= '0;
            end else if (fall_tick) begin
                shreg <= (beat_cnt == '0) ? rdata_spi : (shreg << NLANES);
            end
        end
    end

endmodule

// File: tb/tb_qspi_row_tx.sv
// tb/tb_qspi_row_tx.sv - randomized self-checking bench for qspi_row_tx
module tb_qspi_row_tx;

    localparam int WPR = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n0 = 1'b0;
    logic        rst_n1 = 1'b0;
    logic        start_s      [2] = '{1'b0, 1'b0};
    logic        fifo_empty_s [2] = '{1'b0, 1'b0};
    logic [15:0] rdata_s      [2];
    logic        se_o [2], sclk_o [2], cs_o [2], oe_o [2], busy_o [2], done_o [2];
    logic [3:0]  io_o [2];

    logic [15:0] words [2][64];
    logic [5:0]  widx0, widx1;

    int n_cmp = 0;
    int n_bad = 0;

    qspi_row_tx #(.DWIDTH(16), .NLANES(4), .WORDS_PER_ROW(9), .CLK_DIV(2)) dut0 (
        .clk(clk), .rst_n(rst_n0), .start(start_s[0]), .fifo_empty(fifo_empty_s[0]),
        .rdata_spi(rdata_s[0]), .shift_en(se_o[0]), .sclk(sclk_o[0]), .cs_n(cs_o[0]),
        .io_out(io_o[0]), .io_oe(oe_o[0]), .busy(busy_o[0]), .done(done_o[0]));

    qspi_row_tx #(.DWIDTH(16), .NLANES(4), .WORDS_PER_ROW(9), .CLK_DIV(4)) dut1 (
        .clk(clk), .rst_n(rst_n1), .start(start_s[1]), .fifo_empty(fifo_empty_s[1]),
        .rdata_spi(rdata_s[1]), .shift_en(se_o[1]), .sclk(sclk_o[1]), .cs_n(cs_o[1]),
        .io_out(io_o[1]), .io_oe(oe_o[1]), .busy(busy_o[1]), .done(done_o[1]));

    // FIFO read interface model: word stream, advances on shift_en, realigns on reset.
    always @(posedge clk or negedge rst_n0)
        if (!rst_n0) widx0 <= '0; else if (se_o[0]) widx0 <= widx0 + 6'd1;
    always @(posedge clk or negedge rst_n1)
        if (!rst_n1) widx1 <= '0; else if (se_o[1]) widx1 <= widx1 + 6'd1;
    assign rdata_s[0] = words[0][widx0];
    assign rdata_s[1] = words[1][widx1];

    // Bus observer: event counts and timing-rule violations per DUT.
    int   se_cnt [2] = '{0, 0}, rise_cnt [2] = '{0, 0}, done_cnt [2] = '{0, 0};
    int   busy_cyc [2] = '{0, 0}, widbad [2] = '{0, 0}, gapbad [2] = '{0, 0};
    int   glitch [2] = '{0, 0}, oebad [2] = '{0, 0}, nlow [2] = '{0, 0};
    int   lrun [2] = '{0, 0}, hrun [2] = '{0, 0}, low_len [2] = '{0, 0};
    int   high_len [2] = '{0, 0}, since_se [2] = '{0, 0};
    logic row_se [2] = '{1'b0, 1'b0}, prev_se [2] = '{1'b0, 1'b0};
    logic prev_sclk [2] = '{1'b0, 1'b0}, prev_cs [2] = '{1'b1, 1'b1};
    logic [3:0] prev_io [2] = '{4'h0, 4'h0};
    logic [3:0] nib [2][512];

    function automatic int cdiv(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            prev_se[d]   <= se_o[d];
            prev_sclk[d] <= sclk_o[d];
            prev_io[d]   <= io_o[d];
            prev_cs[d]   <= cs_o[d];
            if (se_o[d]) begin
                se_cnt[d]   <= se_cnt[d] + 1;
                if (prev_se[d]) widbad[d] <= widbad[d] + 1;
                if (row_se[d] && since_se[d] + 1 != 8 * cdiv(d)) gapbad[d] <= gapbad[d] + 1;
                row_se[d]   <= 1'b1;
                since_se[d] <= 0;
            end else begin
                since_se[d] <= since_se[d] + 1;
            end
            if (sclk_o[d] && !prev_sclk[d]) begin
                nib[d][rise_cnt[d] % 512] <= io_o[d];
                rise_cnt[d] <= rise_cnt[d] + 1;
            end
            if (sclk_o[d] && prev_sclk[d] && io_o[d] != prev_io[d]) glitch[d] <= glitch[d] + 1;
            if (oe_o[d] != !cs_o[d]) oebad[d] <= oebad[d] + 1;
            if (done_o[d]) done_cnt[d] <= done_cnt[d] + 1;
            if (busy_o[d]) busy_cyc[d] <= busy_cyc[d] + 1;
            if (!cs_o[d]) begin
                low_len[d] <= prev_cs[d] ? 1 : low_len[d] + 1;
                if (prev_cs[d]) hrun[d] <= high_len[d];
            end else begin
                high_len[d] <= !prev_cs[d] ? 1 : high_len[d] + 1;
                if (!prev_cs[d]) begin
                    lrun[d]   <= low_len[d];
                    nlow[d]   <= nlow[d] + 1;
                    row_se[d] <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int get_widx(input int d);
        return (d == 0) ? int'(widx0) : int'(widx1);
    endfunction

    function automatic int bad_sum(input int d);
        return widbad[d] + gapbad[d] + glitch[d] + oebad[d];
    endfunction

    task automatic load_rand(input int d);
        int b;
        b = get_widx(d);
        for (int i = 0; i < 2 * WPR; i++) words[d][(b + i) % 64] = 16'($urandom);
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check({tag, " shift_en"}, 32'(se_o[d]), 0);
        check({tag, " sclk"},     32'(sclk_o[d]), 0);
        check({tag, " cs_n"},     32'(cs_o[d]), 1);
        check({tag, " io_out"},   32'(io_o[d]), 0);
        check({tag, " io_oe"},    32'(oe_o[d]), 0);
        check({tag, " busy"},     32'(busy_o[d]), 0);
        check({tag, " done"},     32'(done_o[d]), 0);
    endtask

    // One row: expected nibble stream is the next WPR words of the FIFO model,
    // MSB nibble first; frame length is setup + 4 beats x 2 phases x CLK_DIV per word.
    task automatic run_row(input int d, input bit extra, input bit settle,
                           input bit chk_gap, input string tag);
        int se0, r0, dn0, nl0, b0, base, cyc, rowlen;
        bit seen;
        logic [15:0] got;
        se0 = se_cnt[d]; r0 = rise_cnt[d]; dn0 = done_cnt[d]; nl0 = nlow[d]; b0 = bad_sum(d);
        base = get_widx(d);
        rowlen = 74 * cdiv(d);
        fifo_empty_s[d] = 1'b0;
        @(negedge clk); start_s[d] = 1'b1;
        @(negedge clk); start_s[d] = 1'b0;
        seen = 0; cyc = 0;
        while (!seen && cyc < 4000) begin
            @(negedge clk); #1;
            cyc++;
            if (done_o[d]) seen = 1;
            start_s[d] = extra && (cyc < rowlen - 20) && ($urandom_range(0, 7) == 0);
        end
        start_s[d] = 1'b0;
        check({tag, " done seen"}, 32'(seen), 1);
        if (settle) begin
            repeat (40) @(negedge clk);
            #1;
            check({tag, " busy after"}, 32'(busy_o[d]), 0);
        end
        check({tag, " shift_en pulses"}, se_cnt[d] - se0, WPR);
        check({tag, " sclk rises"}, rise_cnt[d] - r0, 4 * WPR);
        check({tag, " done pulses"}, done_cnt[d] - dn0, 1);
        check({tag, " cs_n frames"}, nlow[d] - nl0, 1);
        check({tag, " cs_n low cycles"}, lrun[d], 73 * cdiv(d));
        check({tag, " timing faults"}, bad_sum(d) - b0, 0);
        if (chk_gap) check({tag, " cs_n high gap ok"}, 32'(hrun[d] >= cdiv(d)), 1);
        for (int w = 0; w < WPR; w++) begin
            got = {nib[d][(r0 + 4*w) % 512], nib[d][(r0 + 4*w + 1) % 512],
                   nib[d][(r0 + 4*w + 2) % 512], nib[d][(r0 + 4*w + 3) % 512]};
            check($sformatf("%s word %0d", tag, w), 32'(got), 32'(words[d][(base + w) % 64]));
        end
    endtask

    initial begin
        int se0, r0, nl0, bc0, cyc;
        logic [15:0] basic [WPR];
        basic = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718, 16'h293A,
                  16'h4B5C, 16'h6D7E, 16'h8F90, 16'h5A5A};

        repeat (3) @(negedge clk);
        check_idle_outputs(0, "reset0");
        check_idle_outputs(1, "reset1");
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs(0, "idle0");

        // Basic row with the fixed pattern.
        for (int i = 0; i < WPR; i++) words[0][(get_widx(0) + i) % 64] = basic[i];
        run_row(0, 0, 1, 0, "basic");

        // start while FIFO is empty has no effect.
        se0 = se_cnt[0]; nl0 = nlow[0]; bc0 = busy_cyc[0];
        fifo_empty_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("empty shift_en", se_cnt[0] - se0, 0);
        check("empty cs_n frames", nlow[0] - nl0, 0);
        check("empty busy cycles", busy_cyc[0] - bc0, 0);
        check("empty cs_n", 32'(cs_o[0]), 1);
        load_rand(0);
        run_row(0, 0, 1, 0, "after_empty");

        // Random rows with stray start pulses during the transfer.
        for (int k = 0; k < 2; k++) begin
            load_rand(0);
            run_row(0, 1, 1, 0, $sformatf("extra_start%0d", k));
        end

        // Reset in the middle of word 4, beat 2.
        load_rand(0);
        se0 = se_cnt[0]; r0 = rise_cnt[0];
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        cyc = 0;
        while (rise_cnt[0] - r0 < 18 && cyc < 2000) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("midrow reached", 32'(rise_cnt[0] - r0 >= 18), 1);
        repeat (2) @(negedge clk);
        check("midrow shift_en before reset", se_cnt[0] - se0, 5);
        rst_n0 = 1'b0;
        #1;
        check_idle_outputs(0, "midrow_reset");
        repeat (4) @(negedge clk);
        #1;
        check("midrow no shift_en in reset", se_cnt[0] - se0, 5);
        rst_n0 = 1'b1;
        load_rand(0);
        run_row(0, 0, 1, 0, "post_reset");

        // CLK_DIV=4, back-to-back rows.
        load_rand(1);
        run_row(1, 0, 0, 0, "b2b_row1");
        run_row(1, 0, 1, 1, "b2b_row2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
